// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes shared with the control decoder, and the alu_iter FSM state encoding
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_MUL, OP_SUB};
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle; PW selects product width
module mul_shift_add #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1,
    parameter int PW       = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [PW-1:0]    prod_o
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(STEPS + 1);

    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_acc;
    logic [PW-1:0]    w_part;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;

    // partial product of the multiplicand with the low MUL_STEP multiplier bits
    always_comb begin
        w_part = '0;
        for (int k = 0; k < MUL_STEP; k++)
            if (r_b[k]) w_part = w_part + (r_a << k);
    end

    // load operands on start, then accumulate and shift once per cycle until the count runs out
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (start_i) begin
            r_a   <= PW'(a_i);
            r_b   <= b_i;
            r_acc <= '0;
            r_cnt <= CW'(STEPS);
        end else if (r_cnt != '0) begin
            r_acc <= r_acc + w_part;
            r_a   <= r_a << MUL_STEP;
            r_b   <= r_b >> MUL_STEP;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // the final step's sum is presented combinationally so the caller can register it on that same edge
    assign done_o = r_cnt == CW'(1);
    assign prod_o = r_acc + w_part;

endmodule

// File: rtl/alu_iter.sv
// alu_iter: execution-stage ALU with valid/ready handshake; MUL is iterative. Optional macro ALU_ITER_OVF_EN adds ovf_o.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             illegal_o
`ifdef ALU_ITER_OVF_EN
    ,
    output logic             ovf_o
`endif
);

`ifdef ALU_ITER_OVF_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_done;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
    logic             r_illegal;

    assign w_accept = valid_i && r_state == IDLE;
    assign w_is_mul = ALUCtrl_i == OP_MUL;
    assign w_sum    = data1_i + data2_i;
    assign w_diff   = data1_i - data2_i;
    assign w_res    = ALUCtrl_i == OP_AND ? data1_i & data2_i :
                      ALUCtrl_i == OP_OR  ? data1_i | data2_i :
                      ALUCtrl_i == OP_ADD ? w_sum :
                      ALUCtrl_i == OP_SUB ? w_diff : '0;

`ifdef ALU_ITER_OVF_EN
    logic w_ovf;
    logic r_ovf;
    assign w_ovf = ALUCtrl_i == OP_ADD ? (data1_i[WIDTH-1] == data2_i[WIDTH-1]) && (w_sum[WIDTH-1] != data1_i[WIDTH-1]) :
                   ALUCtrl_i == OP_SUB ? (data1_i[WIDTH-1] != data2_i[WIDTH-1]) && (w_diff[WIDTH-1] != data1_i[WIDTH-1]) : 1'b0;
    assign ovf_o = r_ovf;
`endif

    mul_shift_add #(
        .WIDTH   (WIDTH),
        .MUL_STEP(MUL_STEP),
        .PW      (PW)
    ) u_mul (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(w_accept && w_is_mul),
        .a_i    (data1_i),
        .b_i    (data2_i),
        .done_o (w_mul_done),
        .prod_o (w_prod)
    );

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state: single-cycle ops go straight to DONE, MUL waits for the multiplier
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (valid_i) w_next = w_is_mul ? MUL : DONE;
            MUL:     if (w_mul_done) w_next = DONE;
            DONE:    if (ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // handshake outputs decoded from state; zero flag only meaningful alongside a valid result
    always_comb begin
        ready_o = r_state == IDLE;
        valid_o = r_state == DONE;
        zero_o  = r_zero && valid_o;
    end

    // result registers: loaded on a single-cycle accept or on multiplier completion, held otherwise
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_data    <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_ITER_OVF_EN
            r_ovf     <= 1'b0;
`endif
        end else if (w_accept && !w_is_mul) begin
            r_data    <= w_res;
            r_zero    <= w_res == '0;
            r_illegal <= !op_legal(ALUCtrl_i);
`ifdef ALU_ITER_OVF_EN
            r_ovf     <= w_ovf;
`endif
        end else if (r_state == MUL && w_mul_done) begin
            r_data    <= w_prod[WIDTH-1:0];
            r_zero    <= w_prod[WIDTH-1:0] == '0;
            r_illegal <= 1'b0;
`ifdef ALU_ITER_OVF_EN
            r_ovf     <= |w_prod[PW-1:WIDTH];
`endif
        end
    end

    assign data_o    = r_data;
    assign illegal_o = r_illegal;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter; directed vectors, monitor checks results, latency and hold under backpressure
module tb_alu_iter;

    localparam int W    = 32;
    localparam int STEP = 1;
    localparam int ML   = W / STEP + 1;

    logic          clk     = 1'b0;
    logic          rst_i   = 1'b0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b1;
    logic [2:0]    op      = 3'b000;
    logic [W-1:0]  a       = '0;
    logic [W-1:0]  b       = '0;
    logic          ready_o;
    logic          valid_o;
    logic [W-1:0]  data_o;
    logic          zero_o;
    logic          illegal_o;
`ifdef ALU_ITER_OVF_EN
    logic          ovf_o;
`endif

    alu_iter #(.WIDTH(W), .MUL_STEP(STEP)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .ALUCtrl_i(op),
        .data1_i  (a),
        .data2_i  (b),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .zero_o   (zero_o),
        .illegal_o(illegal_o)
`ifdef ALU_ITER_OVF_EN
        ,
        .ovf_o    (ovf_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         il;
        logic         ov;
        int           lat;
        int           acc;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         il;
        logic         ov;
        int           lat;
    } vec_t;

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", n, act, expv);
        end
    endtask

    exp_t cur;
    bit   seen  = 0;
    bit   cur_ok = 0;
    always @(negedge clk) begin
        if (!valid_o) begin
            seen = 0;
        end else if (!seen) begin
            seen = 1;
            if (q.size() == 0) begin
                cur_ok = 0;
                checks++;
                fails++;
                $display("FAIL unexpected_result got=%h exp=none", data_o);
            end else begin
                cur_ok = 1;
                cur = q.pop_front();
                chk("latency", cyc - cur.acc, cur.lat);
                chk("data", data_o, cur.d);
                chk("zero", zero_o, cur.d == '0);
                chk("illegal", illegal_o, cur.il);
`ifdef ALU_ITER_OVF_EN
                chk("ovf", ovf_o, cur.ov);
`endif
            end
        end else if (cur_ok) begin
            chk("hold_data", data_o, cur.d);
            chk("hold_zero", zero_o, cur.d == '0);
            chk("hold_illegal", illegal_o, cur.il);
        end
    end

    task automatic issue(input vec_t v, input bit push);
        int n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout got=ready_low exp=ready_high");
        end
        op      = v.op;
        a       = v.a;
        b       = v.b;
        valid_i = 1'b1;
        if (push) q.push_back('{v.d, v.il, v.ov, v.lat, cyc});
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        a       = 32'hDEAD_BEEF;
        b       = 32'h1357_9BDF;
    endtask

    task automatic settle();
        int n = 0;
        while ((q.size() != 0 || valid_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL settle_timeout got=pending exp=idle");
        end
    endtask

    vec_t vt[14];

    initial begin
        vt[0]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1};
        vt[1]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1};
        vt[2]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0, 1'b1, ML};
        vt[3]  = '{3'b111, 32'h0000_1234, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1};
        vt[4]  = '{3'b001, 32'h0000_1200, 32'h0000_0034, 32'h0000_1234, 1'b0, 1'b0, 1};
        vt[5]  = '{3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1};
        vt[6]  = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 1};
        vt[7]  = '{3'b011, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, ML};
        vt[8]  = '{3'b011, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0, 1'b1, ML};
        vt[9]  = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b1, ML};
        vt[10] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};
        vt[11] = '{3'b100, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 1};
        vt[12] = '{3'b101, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0, 1};
        vt[13] = '{3'b001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1};

        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        chk("reset_ready", ready_o, 1'b1);
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_data", data_o, '0);
        chk("reset_zero", zero_o, 1'b0);
        chk("reset_illegal", illegal_o, 1'b0);
`ifdef ALU_ITER_OVF_EN
        chk("reset_ovf", ovf_o, 1'b0);
`endif

        foreach (vt[i]) begin
            issue(vt[i], 1'b1);
            settle();
        end

        ready_i = 1'b0;
        issue('{3'b000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1}, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ready", ready_o, 1'b0);
            chk("bp_valid", valid_o, 1'b1);
            valid_i = (k < 4);
            op      = 3'b001;
            a       = 32'h0BAD_0000 + k;
            b       = 32'h0000_00FF;
        end
        ready_i = 1'b1;
        settle();

        issue('{3'b011, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 1'b0, 1'b0, ML}, 1'b0);
        repeat (4) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("midmul_valid", valid_o, 1'b0);
        chk("midmul_data", data_o, '0);
        chk("midmul_ready", ready_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk);
        issue('{3'b011, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 1'b0, 1'b0, ML}, 1'b1);
        settle();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
